// File: rtl/iobus_target_mux_if.sv
// MCS IO bus signal bundle between the bus master, the target mux and its targets.
// slave is the mux view; master is the environment view (MCS plus targets).
interface iobus_target_mux_if #(
  parameter int unsigned NUM_TARGETS = 4
);
  logic                        io_addr_strobe;
  logic [31:0]                 io_address;
  logic [31:0]                 io_read_data;
  logic                        io_ready;
  logic [NUM_TARGETS-1:0]      tgt_addr_strobe;
  logic [32*NUM_TARGETS-1:0]   tgt_read_data;
  logic [NUM_TARGETS-1:0]      tgt_ready;
  logic                        dflt_addr_strobe;
  logic [31:0]                 dflt_read_data;
  logic                        dflt_ready;
  logic                        timeout_flag;
  logic [7:0]                  timeout_count;
  logic                        timeout_clear;

  modport slave (
    input  io_addr_strobe, io_address, tgt_read_data, tgt_ready,
           dflt_read_data, dflt_ready, timeout_clear,
    output io_read_data, io_ready, tgt_addr_strobe, dflt_addr_strobe,
           timeout_flag, timeout_count
  );

  modport master (
    output io_addr_strobe, io_address, tgt_read_data, tgt_ready,
           dflt_read_data, dflt_ready, timeout_clear,
    input  io_read_data, io_ready, tgt_addr_strobe, dflt_addr_strobe,
           timeout_flag, timeout_count
  );
endinterface

// File: rtl/iobus_target_mux.sv
// MCS IO bus address decoder and response mux with a per-transaction watchdog.
// Strobe fan-out and ready/data return are combinational for zero added latency.
module iobus_target_mux #(
  parameter int unsigned NUM_TARGETS   = 4,
  parameter logic [31:0] BASE_ADDR     = 32'hC000_0000,
  parameter int unsigned REGION_BITS   = 8,
  parameter int unsigned TIMEOUT       = 255,
  parameter logic [31:0] TIMEOUT_VALUE = 32'hdead_beef
) (
  input  logic               clk,
  input  logic               rst,
  iobus_target_mux_if.slave  bus
);

  localparam int unsigned HI_W    = 32 - REGION_BITS;
  localparam int unsigned SEL_W   = $clog2(NUM_TARGETS + 1);
  localparam int unsigned CNT_W   = 16;
  localparam logic [HI_W-1:0]  BASE_HI  = HI_W'(BASE_ADDR >> REGION_BITS);
  localparam logic [SEL_W-1:0] DFLT_SEL = SEL_W'(NUM_TARGETS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]             state, state_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic                   timeout_flag_q;
  logic [7:0]             timeout_count_q;

  logic [HI_W-1:0]        diff;
  logic                   hit;
  logic [SEL_W-1:0]       dec_sel;
  logic [SEL_W-1:0]       cur_sel;
  logic                   accept;
  logic                   sel_ready;
  logic [31:0]            sel_data;
  logic                   ready;
  logic [31:0]            rdata;
  logic                   timeout_hit;
  logic [NUM_TARGETS-1:0] tgt_strobe;
  logic                   dflt_strobe;
  logic                   unused_addr_low;

  // Region index is the offset of the upper address bits from the base region.
  assign diff    = bus.io_address[31:REGION_BITS] - BASE_HI;
  assign hit     = (diff < HI_W'(NUM_TARGETS));
  assign dec_sel = hit ? SEL_W'(diff) : DFLT_SEL;
  assign unused_addr_low = ^bus.io_address[REGION_BITS-1:0];

  assign accept  = bus.io_addr_strobe && (state == IDLE) && !rst;
  assign cur_sel = (state == IDLE) ? dec_sel : sel_q;

  always_comb begin
    sel_ready = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (cur_sel == SEL_W'(i)) begin
        sel_ready = bus.tgt_ready[i];
        sel_data  = bus.tgt_read_data[32*i +: 32];
      end
    end
    if (cur_sel == DFLT_SEL) begin
      sel_ready = bus.dflt_ready;
      sel_data  = bus.dflt_read_data;
    end
  end

  always_comb begin
    tgt_strobe  = '0;
    dflt_strobe = 1'b0;
    if (accept) begin
      if (dec_sel == DFLT_SEL) begin
        dflt_strobe = 1'b1;
      end else begin
        for (int i = 0; i < NUM_TARGETS; i++) begin
          if (dec_sel == SEL_W'(i)) tgt_strobe[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d     = state;
    sel_d       = sel_q;
    cnt_d       = cnt;
    ready       = 1'b0;
    rdata       = '0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (sel_ready) begin
            ready = 1'b1;
            rdata = sel_data;
          end else begin
            state_d = BUSY;
            sel_d   = dec_sel;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      BUSY: begin
        if (sel_ready) begin
          ready   = 1'b1;
          rdata   = sel_data;
          state_d = IDLE;
        end else if (cnt == LAST_CNT) begin
          ready       = 1'b1;
          rdata       = TIMEOUT_VALUE;
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // An in-flight transaction is dropped silently by reset.
    if (rst) begin
      ready = 1'b0;
      rdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      sel_q           <= '0;
      cnt             <= '0;
      timeout_flag_q  <= 1'b0;
      timeout_count_q <= '0;
    end else begin
      state <= state_d;
      sel_q <= sel_d;
      cnt   <= cnt_d;
      if (bus.timeout_clear) begin
        timeout_flag_q  <= 1'b0;
        timeout_count_q <= '0;
      end else if (timeout_hit) begin
        timeout_flag_q <= 1'b1;
        if (timeout_count_q != 8'hFF) timeout_count_q <= timeout_count_q + 8'd1;
      end
    end
  end

  assign bus.io_ready         = ready;
  assign bus.io_read_data     = rdata;
  assign bus.tgt_addr_strobe  = tgt_strobe;
  assign bus.dflt_addr_strobe = dflt_strobe;
  assign bus.timeout_flag     = timeout_flag_q;
  assign bus.timeout_count    = timeout_count_q;

endmodule

// File: tb/tb_iobus_target_mux.sv
// Directed bench for iobus_target_mux with 4 targets and an 8-cycle watchdog.
module tb_iobus_target_mux;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  iobus_target_mux_if #(.NUM_TARGETS(4)) bus ();

  iobus_target_mux #(
    .NUM_TARGETS   (4),
    .BASE_ADDR     (32'hC000_0000),
    .REGION_BITS   (8),
    .TIMEOUT       (8),
    .TIMEOUT_VALUE (32'hdead_beef)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.io_addr_strobe = 1'b0;
    bus.io_address     = 32'h0;
    bus.tgt_ready      = 4'b0000;
    bus.dflt_ready     = 1'b0;
    bus.timeout_clear  = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    idle_inputs();
    bus.tgt_read_data  = {32'hD3D3_D3D3, 32'h1234_5678, 32'hB1B1_B1B1, 32'hA0A0_A0A0};
    bus.dflt_read_data = 32'hffff_ffff;

    // Reset: strobe and ready during reset produce nothing.
    next_cycle();
    bus.io_addr_strobe = 1'b1;
    bus.io_address     = 32'h0000_1000;
    bus.dflt_ready     = 1'b1;
    settle();
    check("rst_dflt_strobe", 32'(bus.dflt_addr_strobe), 32'h0);
    check("rst_tgt_strobe",  32'(bus.tgt_addr_strobe),  32'h0);
    check("rst_io_ready",    32'(bus.io_ready),         32'h0);
    check("rst_flag",        32'(bus.timeout_flag),     32'h0);
    check("rst_count",       32'(bus.timeout_count),    32'h0);
    next_cycle();
    rst = 1'b0;

    // Unmapped access answered by the default responder in the same cycle.
    settle();
    check("unmapped_dflt_strobe", 32'(bus.dflt_addr_strobe), 32'h1);
    check("unmapped_tgt_strobe",  32'(bus.tgt_addr_strobe),  32'h0);
    check("unmapped_io_ready",    32'(bus.io_ready),         32'h1);
    check("unmapped_rdata",       bus.io_read_data,          32'hffff_ffff);
    next_cycle();
    idle_inputs();
    settle();
    check("unmapped_after_ready", 32'(bus.io_ready), 32'h0);

    // Mapped target 2, answer after three cycles.
    bus.io_addr_strobe = 1'b1;
    bus.io_address     = 32'hC000_0204;
    settle();
    check("t2_strobe",      32'(bus.tgt_addr_strobe),  32'h4);
    check("t2_dflt_strobe", 32'(bus.dflt_addr_strobe), 32'h0);
    check("t2_c0_ready",    32'(bus.io_ready),         32'h0);
    next_cycle();
    bus.io_address = 32'hC000_0000;
    settle();
    check("busy_strobe_tgt",  32'(bus.tgt_addr_strobe),  32'h0);
    check("busy_strobe_dflt", 32'(bus.dflt_addr_strobe), 32'h0);
    check("t2_c1_ready",      32'(bus.io_ready),         32'h0);
    next_cycle();
    bus.io_addr_strobe = 1'b0;
    bus.tgt_ready      = 4'b0001;
    settle();
    check("t2_c2_other_ready", 32'(bus.io_ready), 32'h0);
    next_cycle();
    bus.tgt_ready = 4'b0100;
    settle();
    check("t2_c3_ready", 32'(bus.io_ready), 32'h1);
    check("t2_c3_rdata", bus.io_read_data,  32'h1234_5678);
    next_cycle();
    idle_inputs();
    settle();
    check("t2_c4_ready", 32'(bus.io_ready),     32'h0);
    check("t2_c4_rdata", bus.io_read_data,      32'h0);

    // Last word of target 3 answered in the strobe cycle.
    bus.io_addr_strobe = 1'b1;
    bus.io_address     = 32'hC000_03FC;
    bus.tgt_ready      = 4'b1000;
    settle();
    check("t3_edge_strobe", 32'(bus.tgt_addr_strobe),  32'h8);
    check("t3_edge_dflt",   32'(bus.dflt_addr_strobe), 32'h0);
    check("t3_edge_ready",  32'(bus.io_ready),         32'h1);
    check("t3_edge_rdata",  bus.io_read_data,          32'hD3D3_D3D3);
    next_cycle();

    // First address past the last region goes to the default port.
    bus.tgt_ready      = 4'b0000;
    bus.io_address     = 32'hC000_0400;
    bus.dflt_ready     = 1'b1;
    bus.dflt_read_data = 32'h55AA_55AA;
    settle();
    check("past_end_tgt",   32'(bus.tgt_addr_strobe),  32'h0);
    check("past_end_dflt",  32'(bus.dflt_addr_strobe), 32'h1);
    check("past_end_rdata", bus.io_read_data,          32'h55AA_55AA);
    next_cycle();

    // Address just below the base also goes to the default port.
    bus.io_address = 32'hBFFF_FFFC;
    settle();
    check("below_base_tgt",  32'(bus.tgt_addr_strobe),  32'h0);
    check("below_base_dflt", 32'(bus.dflt_addr_strobe), 32'h1);
    next_cycle();
    idle_inputs();

    // Target 1 never answers: forced completion in cycle 7.
    bus.io_addr_strobe = 1'b1;
    bus.io_address     = 32'hC000_0100;
    settle();
    check("to_strobe", 32'(bus.tgt_addr_strobe), 32'h2);
    next_cycle();
    bus.io_addr_strobe = 1'b0;
    settle();
    check("to_c1_ready", 32'(bus.io_ready), 32'h0);
    for (int c = 2; c < 7; c++) begin
      next_cycle();
      check("to_wait_ready", 32'(bus.io_ready), 32'h0);
    end
    next_cycle();
    check("to_c7_ready", 32'(bus.io_ready),     32'h1);
    check("to_c7_rdata", bus.io_read_data,      32'hdead_beef);
    check("to_c7_flag",  32'(bus.timeout_flag), 32'h0);
    next_cycle();
    check("to_c8_ready", 32'(bus.io_ready),      32'h0);
    check("to_c8_flag",  32'(bus.timeout_flag),  32'h1);
    check("to_c8_count", 32'(bus.timeout_count), 32'h1);
    next_cycle();
    next_cycle();
    bus.tgt_ready = 4'b0010;
    settle();
    check("late_ready_ignored", 32'(bus.io_ready), 32'h0);
    next_cycle();
    idle_inputs();

    // 259 more timeouts on target 0; the counter saturates at 255.
    for (int n = 2; n <= 260; n++) begin
      bus.io_addr_strobe = 1'b1;
      bus.io_address     = 32'hC000_0000;
      next_cycle();
      bus.io_addr_strobe = 1'b0;
      repeat (6) next_cycle();
      check("sat_timeout_ready", 32'(bus.io_ready), 32'h1);
      next_cycle();
      if (n == 255) check("count_at_255", 32'(bus.timeout_count), 32'd255);
    end
    check("sat_count", 32'(bus.timeout_count), 32'd255);
    check("sat_flag",  32'(bus.timeout_flag),  32'h1);

    bus.timeout_clear = 1'b1;
    next_cycle();
    bus.timeout_clear = 1'b0;
    check("clear_flag",  32'(bus.timeout_flag),  32'h0);
    check("clear_count", 32'(bus.timeout_count), 32'h0);

    // Clear asserted in the timeout cycle wins over the increment.
    bus.io_addr_strobe = 1'b1;
    bus.io_address     = 32'hC000_0300;
    next_cycle();
    bus.io_addr_strobe = 1'b0;
    repeat (6) next_cycle();
    bus.timeout_clear = 1'b1;
    settle();
    check("clear_race_ready", 32'(bus.io_ready), 32'h1);
    next_cycle();
    bus.timeout_clear = 1'b0;
    check("clear_race_flag",  32'(bus.timeout_flag),  32'h0);
    check("clear_race_count", 32'(bus.timeout_count), 32'h0);

    // Reset in cycle 2 of a pending access abandons it.
    bus.io_addr_strobe = 1'b1;
    bus.io_address     = 32'hC000_0200;
    next_cycle();
    bus.io_addr_strobe = 1'b0;
    next_cycle();
    rst                = 1'b1;
    bus.io_addr_strobe = 1'b1;
    bus.tgt_ready      = 4'b0100;
    settle();
    check("mid_rst_ready",  32'(bus.io_ready),        32'h0);
    check("mid_rst_rdata",  bus.io_read_data,         32'h0);
    check("mid_rst_strobe", 32'(bus.tgt_addr_strobe), 32'h0);
    next_cycle();
    rst = 1'b0;
    idle_inputs();
    bus.tgt_ready = 4'b0100;
    for (int c = 0; c < 8; c++) begin
      settle();
      check("post_rst_no_ready", 32'(bus.io_ready), 32'h0);
      next_cycle();
    end
    idle_inputs();

    // Fresh access to target 0 answered one cycle later.
    bus.io_addr_strobe = 1'b1;
    bus.io_address     = 32'hC000_0010;
    settle();
    check("post_rst_strobe", 32'(bus.tgt_addr_strobe), 32'h1);
    next_cycle();
    bus.io_addr_strobe = 1'b0;
    bus.tgt_ready      = 4'b0001;
    settle();
    check("post_rst_ready", 32'(bus.io_ready), 32'h1);
    check("post_rst_rdata", bus.io_read_data,  32'hA0A0_A0A0);
    next_cycle();
    idle_inputs();
    settle();
    check("post_rst_done", 32'(bus.io_ready), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iobus_target_mux.md
# iobus_target_mux

Address decoder and response multiplexer for the MicroBlaze MCS IO bus. It sits between the MCS IO bus master and the peripheral targets. It routes the address strobe to one of NUM_TARGETS decoded regions, or to the default-response port for unmapped addresses, and returns the selected target's read data and ready. A watchdog completes any transaction whose target fails to answer within TIMEOUT cycles, so the bus never hangs.

## Interface
- NUM_TARGETS, 4: number of decoded target regions (1..16).
- BASE_ADDR, 32'hC0000000: address of target 0 region.
- REGION_BITS, 8: log2 region size in bytes; target i occupies BASE_ADDR + (i << REGION_BITS).
- TIMEOUT, 255: cycles after strobe before forced completion (2..65535).
- TIMEOUT_VALUE, 32'hdeadbeef: read data returned on a timed-out transaction.

- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- io_addr_strobe  in  1  MCS address strobe, one-cycle pulse per transaction.
- io_address  in  32  MCS address, valid only in the strobe cycle.
- io_read_data  out  32  read data to MCS.
- io_ready  out  1  transaction complete to MCS.
- tgt_addr_strobe  out  NUM_TARGETS  per-target strobe, bit i for region i.
- tgt_read_data  in  32*NUM_TARGETS  target i data at bits [32i+31:32i].
- tgt_ready  in  NUM_TARGETS  per-target ready.
- dflt_addr_strobe  out  1  strobe to the default responder.
- dflt_read_data  in  32  default responder data.
- dflt_ready  in  1  default responder ready.
- timeout_flag  out  1  sticky: at least one timeout since reset or clear.
- timeout_count  out  8  saturating count of timeouts.
- timeout_clear  in  1  clears timeout_flag and timeout_count.

Address/write data, read/write strobes and byte enables are broadcast by the top level and do not pass through this block.

## Operation
- Decode:
  - hit when io_address[31:REGION_BITS] - (BASE_ADDR >> REGION_BITS) < NUM_TARGETS.
  - index = that difference.
  - Otherwise the default port is selected.
- Strobe fan-out is combinational: in the strobe cycle, exactly one of tgt_addr_strobe[index] / dflt_addr_strobe equals io_addr_strobe. All strobe outputs are 0 in every other cycle and while rst=1.
- States IDLE, BUSY.
  - IDLE and strobe:
    - the decoded selection is used combinationally;
    - if the selected ready=1 in the same cycle, io_ready=1 and the state stays IDLE;
    - otherwise the selection is latched into sel_q, the counter cnt is loaded with 1, and the state moves to BUSY.
  - BUSY, selected ready=1: io_ready=1, io_read_data = selected data, go to IDLE.
  - BUSY, no ready and cnt == TIMEOUT-1:
    - io_ready=1, io_read_data=TIMEOUT_VALUE, go to IDLE;
    - timeout_flag is set; timeout_count increments, saturating at 255.
  - BUSY otherwise: cnt increments.
- io_read_data:
  - selected source data whenever a ready is passed through;
  - TIMEOUT_VALUE on timeout;
  - 0 otherwise.
- Readies from non-selected targets are ignored. In IDLE without a strobe, all readies are ignored; late readies after a timeout are discarded.
- A strobe while BUSY is ignored: no fan-out, no effect on state.
- timeout_clear: flag and count go to 0 on the next edge. If a timeout occurs in the same cycle, the clear wins.
- Reset:
  - state IDLE; cnt, sel_q, timeout_flag and timeout_count are 0;
  - io_ready=0 and all strobes are 0 while rst=1;
  - an in-flight transaction is abandoned with no io_ready.

## Timing
- Strobe in cycle 0, combinational target ready in cycle 0: io_ready in cycle 0 (zero added latency).
- Target ready in cycle k (1 ≤ k ≤ TIMEOUT-1): io_ready in cycle k.
- No ready: io_ready with TIMEOUT_VALUE in cycle TIMEOUT-1. timeout_flag and timeout_count are visible in cycle TIMEOUT.
- io_ready is high for exactly one cycle per accepted strobe.
- A new strobe is accepted in the cycle after io_ready.

## Test plan
- Unmapped access: strobe at 32'h00001000 with default responder (ready=strobe, data 32'hffffffff) → dflt_addr_strobe=1, io_ready=1 and io_read_data=32'hffffffff in the same cycle, all tgt_addr_strobe=0.
- Mapped delayed: strobe at 32'hC0000204 → tgt_addr_strobe=4'b0100; target 2 asserts ready with 32'h12345678 three cycles later → io_ready=1 with 32'h12345678 in cycle 3, state IDLE.
- Region boundary: addresses 32'hC00003FC (target 3) and 32'hC0000400 (default) → correct single strobe each.
- Timeout, TIMEOUT=8: strobe to target 1, never ready → io_ready with 32'hdeadbeef in cycle 7; timeout_flag=1, timeout_count=1 in cycle 8. A late tgt_ready[1] in cycle 10 produces no io_ready.
- Saturation/clear: 260 timeouts → timeout_count=255. Then timeout_clear → flag=0, count=0.
- Reset mid-transaction: rst in cycle 2 of a BUSY access → io_ready never asserted, outputs 0. A strobe after reset completes normally.
